// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 8-digit packed BCD converter (double dabble).
// One bit per clock; results are registered and held until the next done pulse.
module bin2bcd_seq #(
  parameter bit SAT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        ovf
);

  localparam int unsigned BIN_W  = 32;
  localparam int unsigned DIGITS = 10;
  localparam int unsigned ACC_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned OUT_W  = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [BIN_W-1:0]   sr;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W-1:0]       adj;
  logic [ACC_W+BIN_W-1:0] shv;
  logic [ACC_W-1:0]       acc_nxt;
  logic [BIN_W-1:0]       sr_nxt;
  logic                   ovf_nxt;

  // Add-3 correction on every digit that would reach 10 or more after the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign shv     = {adj, sr} << 1;
  assign acc_nxt = shv[ACC_W+BIN_W-1:BIN_W];
  assign sr_nxt  = shv[BIN_W-1:0];
  assign ovf_nxt = |acc_nxt[ACC_W-1:OUT_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= bin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          sr  <= sr_nxt;
          cnt <= cnt + CNT_W'(1);
          // Last iteration: publish the post-shift accumulator in the same edge
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            ovf   <= ovf_nxt;
            bcd   <= (SAT && ovf_nxt) ? 32'h9999_9999 : acc_nxt[OUT_W-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: saturating and wrapping instances share stimulus.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        busy_s, done_s, ovf_s;
  logic        busy_n, done_n, ovf_n;
  logic [31:0] bcd_s, bcd_n;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] bs;
    logic [31:0] bn;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e_m;

  bin2bcd_seq #(.SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_s), .done(done_s), .bcd(bcd_s), .ovf(ovf_s)
  );

  bin2bcd_seq #(.SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_n), .done(done_n), .bcd(bcd_n), .ovf(ovf_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done_s || done_n) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cyc %0d expected none", cyc);
      end else begin
        e_m = q.pop_front();
        chk("done_sat",  32'(done_s), 32'd1);
        chk("done_wrap", 32'(done_n), 32'd1);
        chk("latency",   32'(cyc),    32'(e_m.cyc));
        chk("bcd_sat",   bcd_s,       e_m.bs);
        chk("bcd_wrap",  bcd_n,       e_m.bn);
        chk("ovf_sat",   32'(ovf_s),  32'(e_m.ovf));
        chk("ovf_wrap",  32'(ovf_n),  32'(e_m.ovf));
      end
    end
  end

  task automatic conv(input logic [31:0] v, input logic [31:0] bs, input logic [31:0] bn,
                      input logic ov, input bit push, output int k);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    k = cyc;
    if (push) q.push_back('{bs: bs, bn: bn, ovf: ov, cyc: k + 32});
    start = 1'b0;
    bin   = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy_s || busy_n) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'({busy_s, busy_n}), 32'd0);
    chk({tag, "_done"}, 32'({done_s, done_n}), 32'd0);
    chk({tag, "_bcd_sat"},  bcd_s, 32'h0);
    chk({tag, "_bcd_wrap"}, bcd_n, 32'h0);
    chk({tag, "_ovf"},  32'({ovf_s, ovf_n}), 32'd0);
  endtask

  initial begin
    int k;
    int lows;
    rst   = 1'b0;
    start = 1'b0;
    bin   = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    conv(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, k);
    drain();
    conv(32'h00BC_614E, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, k);
    drain();
    conv(32'h05F5_E0FF, 32'h9999_9999, 32'h9999_9999, 1'b0, 1'b1, k);
    drain();
    conv(32'h05F5_E100, 32'h9999_9999, 32'h0000_0000, 1'b1, 1'b1, k);
    drain();
    conv(32'hFFFF_FFFF, 32'h9999_9999, 32'h9496_7295, 1'b1, 1'b1, k);
    drain();

    // Restarts during SHIFT and during DONE are ignored
    conv(32'd42, 32'h0000_0042, 32'h0000_0042, 1'b0, 1'b1, k);
    while (cyc < k + 5) @(negedge clk);
    start = 1'b1; bin = 32'd5;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 32) @(negedge clk);
    chk("busy_in_done", 32'(busy_s), 32'd1);
    start = 1'b1; bin = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("hold_bcd", bcd_s, 32'h0000_0042);
    chk("idle_after_ignore", 32'(busy_s), 32'd0);

    // Reset mid-conversion aborts without a done pulse
    conv(32'd99, 32'h0, 32'h0, 1'b0, 1'b0, k);
    while (cyc < k + 10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_reset_outputs("abort");
    repeat (40) @(negedge clk);
    conv(32'd7, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, k);
    drain();

    // Start held high: back-to-back conversions every 34 clocks
    @(negedge clk);
    start = 1'b1;
    bin   = 32'd1;
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 3; i++)
      q.push_back('{bs: 32'h1, bn: 32'h1, ovf: 1'b0, cyc: k + 32 + 34 * i});
    lows = 0;
    repeat (99) begin
      @(negedge clk);
      if (!busy_s) lows++;
      if (cyc == k + 33) chk("gap_busy_low", 32'(busy_s), 32'd0);
      if (cyc == k + 34) chk("restart_busy", 32'(busy_s), 32'd1);
    end
    start = 1'b0;
    chk("gap_count", 32'(lows), 32'd2);
    drain();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
